// File: rtl/hologram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hologram_pkg
// Brief    : Shared types and helpers for the POV hologram column pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package hologram_pkg;

    localparam int COLOR_W = 24;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        CAPTURE  = 3'd2,
        HANDOFF  = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    // Bit offset of LED i inside the flat driver bus.
    function automatic int led_slice(input int i);
        return i * COLOR_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/column_streamer.sv
`default_nettype none
// ============================================================================
// Module   : column_streamer
// Brief    : Fetches one LED column per tick from image RAM and hands it to
//            the WS2812 driver over a start/busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module column_streamer
    import hologram_pkg::*;
#(
    parameter int LED_COUNT    = 8,
    parameter int COLUMN_COUNT = 64,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              col_tick,
    input  logic                              sync,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [COLOR_W-1:0]                mem_rdata,
    output logic [LED_COUNT*COLOR_W-1:0]      drv_data,
    output logic                              drv_start,
    input  logic                              drv_busy,
    output logic [$clog2(COLUMN_COUNT)-1:0]   col_idx,
    output logic                              overrun
);

    localparam int c_COL_W = (COLUMN_COUNT > 1) ? $clog2(COLUMN_COUNT) : 1;
    localparam int c_K_W   = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(LED_COUNT - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLUMN_COUNT - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_K_W-1:0]                r_k;
    logic [c_COL_W-1:0]              r_next_col;
    logic [c_COL_W-1:0]              r_fetch_col;
    logic [ADDR_WIDTH-1:0]           r_mem_addr;
    logic                            r_wr_en;
    logic [c_K_W-1:0]                r_wr_idx;
    logic [COLOR_W-1:0]              r_shadow [LED_COUNT];
    logic [LED_COUNT*COLOR_W-1:0]    r_drv_data;
    logic                            r_drv_start;
    logic [c_COL_W-1:0]              r_col_idx;
    logic                            r_overrun;

    logic                            w_accept;
    logic                            w_copy;
    logic [c_COL_W-1:0]              w_accept_col;
    logic [c_COL_W-1:0]              w_col_inc;
    logic [ADDR_WIDTH-1:0]           w_base;
    logic [LED_COUNT*COLOR_W-1:0]    w_shadow_flat;

    assign w_accept     = (r_state == IDLE) && col_tick;
    assign w_copy       = (r_state == HANDOFF) && !drv_busy;
    // A coincident sync forces this tick onto column 0.
    assign w_accept_col = sync ? '0 : r_next_col;
    assign w_col_inc    = (w_accept_col == c_COL_LAST) ? '0 : w_accept_col + 1'b1;
    assign w_base       = ADDR_WIDTH'(w_accept_col) * ADDR_WIDTH'(LED_COUNT);

    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_pack
        assign w_shadow_flat[led_slice(gi) +: COLOR_W] = r_shadow[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (col_tick) w_state_nxt = FETCH;
            FETCH:    if (r_k == c_K_LAST) w_state_nxt = CAPTURE;
            CAPTURE:  w_state_nxt = HANDOFF;
            HANDOFF:  if (!drv_busy) w_state_nxt = WAIT_ACK;
            WAIT_ACK: if (drv_busy) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k         <= '0;
            r_next_col  <= '0;
            r_fetch_col <= '0;
            r_mem_addr  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_drv_data  <= '0;
            r_drv_start <= 1'b0;
            r_col_idx   <= '0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < LED_COUNT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            // RAM latency is one cycle, so each write trails its address by one.
            r_wr_en  <= (r_state == FETCH);
            r_wr_idx <= r_k;
            if (r_wr_en) begin
                r_shadow[r_wr_idx] <= mem_rdata;
            end

            if (w_accept) begin
                r_next_col <= w_col_inc;
            end else if (sync) begin
                r_next_col <= '0;
            end

            if (w_accept) begin
                r_fetch_col <= w_accept_col;
                r_k         <= '0;
                r_mem_addr  <= w_base;
            end else if ((r_state == FETCH) && (r_k != c_K_LAST)) begin
                r_k         <= r_k + 1'b1;
                r_mem_addr  <= r_mem_addr + 1'b1;
            end

            if (w_copy) begin
                r_drv_data <= w_shadow_flat;
                r_col_idx  <= r_fetch_col;
            end

            r_drv_start <= (w_state_nxt == WAIT_ACK);
            r_overrun   <= col_tick && (r_state != IDLE);
        end
    end

    assign mem_addr  = r_mem_addr;
    assign drv_data  = r_drv_data;
    assign drv_start = r_drv_start;
    assign col_idx   = r_col_idx;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
